// File: rtl/ram_arb_pkg.sv
// Purpose: shared types for the RAM port arbiter (requester select, read-return tag).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    // Which requester owns an access; also carried by read tags to steer rvalid.
    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_sel_e;

    typedef struct packed {
        logic     valid;
        arb_sel_e sel;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, sel: ARB_M0};

endpackage

// File: rtl/ram_arb_rd_tracker.sv
// Purpose: delay line that follows each granted read to the cycle its RAM data is valid.
// Latency: DEPTH cycles from tag_i to tag_o.
// Backpressure: none; one tag accepted and one retired every cycle.
//
// Ports:
//   clk, rst_n  clock and async active-low clear (drops all in-flight tags)
//   tag_i       tag of the access granted this cycle (valid=0 for writes/idle)
//   tag_o       tag leaving the pipe, aligned with the RAM read data
module ram_arb_rd_tracker
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= RD_TAG_IDLE;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one RAM port between M0 (data) and M1 (fetch); M0 priority, M1 anti-starvation.
// Latency: grant combinational; read data READ_LATENCY cycles after grant, rvalid aligned.
// Backpressure: a requester holds req until its gnt; at most one grant per cycle, no queueing.
//
// Ports:
//   clk, rst_n                        clock and async active-low reset
//   m0_req/we/addr/wdata, m0_gnt      M0 request fields and same-cycle grant
//   m0_rvalid                         rdata holds an M0 read result this cycle
//   m1_req/we/addr/wdata, m1_gnt      M1 request fields and same-cycle grant
//   m1_rvalid                         rdata holds an M1 read result this cycle
//   rdata                             read-return bus, straight from ram_rdata
//   ram_en/we/addr/wdata, ram_rdata   RAM CPU-side port
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam bit   STARVE_EN = (STARVE_LIMIT > 0);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             m1_urgent;
    rd_tag_t          tag_d, tag_exit;

    // Grants are gated with rst_n so every RAM-side output is low for the whole
    // reset interval, not just from the next clock edge.
    always_comb begin
        m1_urgent = STARVE_EN && (starve_cnt_q == LIMIT);
        m1_gnt    = rst_n && m1_req && (!m0_req || m1_urgent);
        m0_gnt    = rst_n && m0_req && !m1_gnt;
    end

    // Counts consecutive cycles M1 has been kept waiting; saturates so M1 keeps
    // priority until it is actually served.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || m1_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
        ram_en = m0_gnt | m1_gnt;
    end

    // Only reads launch a tag; writes return nothing.
    always_comb begin
        tag_d.valid = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
        tag_d.sel   = m1_gnt ? ARB_M1 : ARB_M0;
    end

    ram_arb_rd_tracker #(
        .DEPTH (READ_LATENCY)
    ) u_rd_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_d),
        .tag_o (tag_exit)
    );

    assign m0_rvalid = tag_exit.valid && (tag_exit.sel == ARB_M0);
    assign m1_rvalid = tag_exit.valid && (tag_exit.sel == ARB_M1);
    assign rdata     = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: checks two arbiter configurations (lat 1 / limit 4, lat 2 / strict) against a reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_ram_port_arbiter;

    localparam int RL_A = 1;
    localparam int SL_A = 4;
    localparam int RL_B = 2;
    localparam int SL_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic        m0_gnt_o [2];
    logic        m1_gnt_o [2];
    logic        m0_rvalid_o [2];
    logic        m1_rvalid_o [2];
    logic [31:0] rdata_o [2];
    logic        ram_en_o [2];
    logic        ram_we_o [2];
    logic [7:0]  ram_addr_o [2];
    logic [31:0] ram_wdata_o [2];
    logic [31:0] ram_rdata_i [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rd1, rd2;

        ram_port_arbiter #(
            .ADDR_WIDTH   (8),
            .DATA_WIDTH   (32),
            .READ_LATENCY ((k == 0) ? RL_A : RL_B),
            .STARVE_LIMIT ((k == 0) ? SL_A : SL_B)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (m0_gnt_o[k]),
            .m0_rvalid (m0_rvalid_o[k]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_gnt    (m1_gnt_o[k]),
            .m1_rvalid (m1_rvalid_o[k]),
            .rdata     (rdata_o[k]),
            .ram_en    (ram_en_o[k]),
            .ram_we    (ram_we_o[k]),
            .ram_addr  (ram_addr_o[k]),
            .ram_wdata (ram_wdata_o[k]),
            .ram_rdata (ram_rdata_i[k])
        );

        // Simple synchronous RAM: one registered read stage, plus a second for latency 2.
        always @(posedge clk) begin
            if (ram_en_o[k] && ram_we_o[k]) mem[ram_addr_o[k]] <= ram_wdata_o[k];
            if (ram_en_o[k] && !ram_we_o[k]) rd1 <= mem[ram_addr_o[k]];
            rd2 <= rd1;
        end
        assign ram_rdata_i[k] = (k == 0) ? rd1 : rd2;
    end

    // Reference model state: expected memory contents, M1 waiting time,
    // and read returns scheduled by the cycle number on which they are due.
    logic [31:0] refm [2][256];
    int          waitc [2];
    logic        sv   [2][4];
    logic        ssel [2][4];
    logic [31:0] sdat [2][4];
    int          run   [2];
    int          g1cnt [2];
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // One clock cycle: check both instances against the model, then advance the model.
    task automatic step();
        logic        eg0 [2];
        logic        eg1 [2];
        logic        ewe [2];
        logic [7:0]  ea  [2];
        logic [31:0] ed  [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            int   sl;
            int   slot;
            logic m1w, erv0, erv1;
            sl   = (k == 0) ? SL_A : SL_B;
            slot = cyc % 4;
            eg0[k] = 1'b0; eg1[k] = 1'b0; ewe[k] = 1'b0; ea[k] = '0; ed[k] = '0;
            erv0 = 1'b0; erv1 = 1'b0;
            if (rst_n) begin
                m1w    = m1_req && (!m0_req || (sl > 0 && waitc[k] >= sl));
                eg1[k] = m1w;
                eg0[k] = m0_req && !m1w;
                if (eg0[k]) begin
                    ewe[k] = m0_we; ea[k] = m0_addr; ed[k] = m0_wdata;
                end else if (eg1[k]) begin
                    ewe[k] = m1_we; ea[k] = m1_addr; ed[k] = m1_wdata;
                end
                erv0 = sv[k][slot] && !ssel[k][slot];
                erv1 = sv[k][slot] && ssel[k][slot];
            end
            chk(k, "m0_gnt", m0_gnt_o[k], eg0[k]);
            chk(k, "m1_gnt", m1_gnt_o[k], eg1[k]);
            chk(k, "ram_en", ram_en_o[k], eg0[k] | eg1[k]);
            chk(k, "ram_we", ram_we_o[k], ewe[k]);
            chk(k, "ram_addr", ram_addr_o[k], ea[k]);
            chk(k, "ram_wdata", ram_wdata_o[k], ed[k]);
            chk(k, "m0_rvalid", m0_rvalid_o[k], erv0);
            chk(k, "m1_rvalid", m1_rvalid_o[k], erv1);
            if (erv0 || erv1) chk(k, "rdata", rdata_o[k], sdat[k][slot]);
            if (m1_gnt_o[k]) g1cnt[k]++;
            if (rst_n && m1_req && !m1_gnt_o[k]) run[k]++;
            else run[k] = 0;
            if (k == 0) chk(k, "m1_wait_bound", (run[k] <= SL_A), 1);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int rl;
            int sl;
            rl = (k == 0) ? RL_A : RL_B;
            sl = (k == 0) ? SL_A : SL_B;
            if (!rst_n) begin
                waitc[k] = 0;
                for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            end else begin
                sv[k][cyc % 4] = 1'b0;
                if (eg0[k] || eg1[k]) begin
                    if (ewe[k]) begin
                        refm[k][ea[k]] = ed[k];
                    end else begin
                        sv[k][(cyc + rl) % 4]   = 1'b1;
                        ssel[k][(cyc + rl) % 4] = eg1[k];
                        sdat[k][(cyc + rl) % 4] = refm[k][ea[k]];
                    end
                end
                if (m1_req && !eg1[k]) waitc[k] = (waitc[k] < sl) ? waitc[k] + 1 : sl;
                else waitc[k] = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            waitc[k] = 0; run[k] = 0; g1cnt[k] = 0;
            for (int s = 0; s < 4; s++) begin
                sv[k][s] = 1'b0; ssel[k][s] = 1'b0; sdat[k][s] = '0;
            end
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h05, 32'h0, 1'b1, 1'b0, 8'h06, 32'h0);
        @(negedge clk);

        // Reset: requests present but every output must stay low.
        step();
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();

        // Preload addresses 0..15 through M0 so later reads have known data.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 8'(i), $urandom, 1'b0, 1'b0, 8'h0, 32'h0);
            step();
        end

        // M0 write then read of 0x10; data returns after the read latency.
        drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        #1;
        chk(0, "t1_m0_rvalid", m0_rvalid_o[0], 1'b1);
        chk(0, "t1_rdata", rdata_o[0], 32'hDEADBEEF);
        step();
        step();
        step();

        // Both requesting continuously: 4:1 pattern with limit 4, M1 shut out when strict.
        g1cnt[0] = 0;
        g1cnt[1] = 0;
        drive(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
        for (int i = 0; i < 20; i++) step();
        chk(0, "t2_m1_grants", g1cnt[0], 4);
        chk(1, "t3_m1_grants", g1cnt[1], 0);
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
        #1;
        chk(1, "t3_m1_gnt_on_drop", m1_gnt_o[1], 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(); step(); step();

        // Alternating back-to-back reads M0@1, M1@2, M0@3.
        drive(1'b1, 1'b0, 8'h01, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
        step();
        drive(1'b1, 1'b0, 8'h03, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(); step(); step();

        // M1 write to 0x20 then M0 read of 0x20.
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1, 8'h20, 32'h55);
        step();
        drive(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(); step(); step();

        // Reset while a read is in flight: nothing may return afterwards.
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), $urandom);
            step();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
